// File: rtl/apb_cmd_master_pkg.sv
// apb_master_pkg: shared types and constants for the APB command master.
//   state_t       - transfer FSM states (IDLE, SETUP, ACCESS)
//   PPROT_*       - APB4 pprot bit meanings
//   ERR_COUNT_W   - width of the saturating error counter
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  localparam logic [2:0] PPROT_PRIV   = 3'b001;
  localparam logic [2:0] PPROT_NONSEC = 3'b010;
  localparam logic [2:0] PPROT_INSTR  = 3'b100;

  localparam int unsigned ERR_COUNT_W = 16;

endpackage

// File: rtl/apb_cmd_master_if.sv
// apb_cmd_master_if: APB4 bus bundle.
//   master modport drives paddr/pprot/psel/penable/pwrite/pwdata/pstrb and
//   samples pready/prdata/pslverr; slave modport is the mirror image.
interface apb_cmd_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   paddr;
  logic [2:0]          pprot;
  logic                psel;
  logic                penable;
  logic                pwrite;
  logic [DATA_W-1:0]   pwdata;
  logic [DATA_W/8-1:0] pstrb;
  logic                pready;
  logic [DATA_W-1:0]   prdata;
  logic                pslverr;

  modport master (
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_cmd_master_sync_fifo.sv
// apb_sync_fifo: single-clock FIFO, power-of-2 depth, async active-low reset.
//   clk, rst_n         - clock / reset
//   push, push_data    - write side (ignored when full)
//   pop, head          - read side; head shows the oldest entry (ignored when empty)
//   full, empty        - occupancy flags
module apb_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: APB4 master driven by a valid/ready command stream.
//   pclk, presetn              - clock, async active-low reset
//   cmd_valid/cmd_ready, cmd_* - command in (write, addr, wdata, strb, prot)
//   rsp_valid/rsp_ready, rsp_* - one response per command (rdata, err, timeout)
//   busy                       - queued command, transfer in flight or response pending
//   err_count                  - saturating count of error responses
//   apb                        - APB4 master port
module apb_cmd_master
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned TIMEOUT   = 256
) (
  input  logic                   pclk,
  input  logic                   presetn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDR_W-1:0]      cmd_addr,
  input  logic [DATA_W-1:0]      cmd_wdata,
  input  logic [DATA_W/8-1:0]    cmd_strb,
  input  logic [2:0]             cmd_prot,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   rsp_timeout,
  output logic                   busy,
  output logic [ERR_COUNT_W-1:0] err_count,
  apb_cmd_master_if.master       apb
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CMD_W  = 1 + ADDR_W + DATA_W + STRB_W + 3;
  localparam int unsigned TCNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TLAST = TCNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
    logic [2:0]        prot;
  } cmd_t;

  state_t                 state;
  cmd_t                   head;
  logic [CMD_W-1:0]       head_bits;
  logic                   fifo_full, fifo_empty, ready_q, push, pop;
  logic                   timeout_hit, fill_err;
  logic [TCNT_W-1:0]      tcnt;
  logic [ERR_COUNT_W-1:0] err_cnt;

  logic [ADDR_W-1:0] paddr_q;
  logic [2:0]        pprot_q;
  logic              psel_q, penable_q, pwrite_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [STRB_W-1:0] pstrb_q;

  // ready_q holds cmd_ready low for the first cycle after reset release.
  assign cmd_ready = ready_q && !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && !fifo_empty && (!rsp_valid || rsp_ready);
  assign head      = cmd_t'(head_bits);
  assign busy      = !fifo_empty || (state != IDLE) || rsp_valid;
  assign err_count = err_cnt;

  // The TIMEOUT-th ACCESS cycle has tcnt == TIMEOUT-1; pready still wins there.
  assign timeout_hit = (TIMEOUT != 0) && (tcnt == TLAST);
  assign fill_err    = apb.pready ? apb.pslverr : 1'b1;

  assign apb.paddr   = paddr_q;
  assign apb.pprot   = pprot_q;
  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.pwdata  = pwdata_q;
  assign apb.pstrb   = pstrb_q;

  apb_sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk       (pclk),
    .rst_n     (presetn),
    .push      (push),
    .push_data ({cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot}),
    .pop       (pop),
    .head      (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state       <= IDLE;
      ready_q     <= 1'b0;
      tcnt        <= '0;
      err_cnt     <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      paddr_q     <= '0;
      pprot_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
    end else begin
      ready_q <= 1'b1;
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (pop) begin
            state     <= SETUP;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            paddr_q   <= head.addr;
            pwrite_q  <= head.write;
            pprot_q   <= head.prot;
            pwdata_q  <= head.write ? head.wdata : '0;
            pstrb_q   <= head.write ? head.strb  : '0;
            tcnt      <= '0;
          end
        end
        SETUP: begin
          state     <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          if (apb.pready || timeout_hit) begin
            state       <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pprot_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= (apb.pready && !pwrite_q) ? apb.prdata : '0;
            rsp_err     <= fill_err;
            rsp_timeout <= !apb.pready;
            if (fill_err && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: directed bench for apb_cmd_master (CMD_DEPTH=4, TIMEOUT=8)
// with a configurable APB slave model (wait states, error, endless stall).
module tb_apb_cmd_master;
  import apb_master_pkg::*;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_strb = '0;
  logic [2:0]  cmd_prot = '0;
  logic        rsp_valid, rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout, busy;
  logic [15:0] err_count;

  int          n_checks = 0, n_errors = 0;
  int unsigned ws_cfg = 0;
  logic        stall_all = 1'b0, slverr_cfg = 1'b0;
  logic [31:0] rdata_cfg = '0;
  int unsigned acc_cnt = 0, setup_cnt = 0, rsp_cnt = 0;

  apb_cmd_master_if #(.ADDR_W(32), .DATA_W(32)) apb ();

  apb_cmd_master #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .CMD_DEPTH (4),
    .TIMEOUT   (8)
  ) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_strb    (cmd_strb),
    .cmd_prot    (cmd_prot),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .busy        (busy),
    .err_count   (err_count),
    .apb         (apb)
  );

  always #5 pclk = ~pclk;

  // Slave: pready after ws_cfg wait states unless stalled forever.
  assign apb.pready  = apb.psel && apb.penable && !stall_all && (acc_cnt == ws_cfg);
  assign apb.prdata  = apb.pready ? rdata_cfg : '0;
  assign apb.pslverr = apb.pready && slverr_cfg;

  always @(posedge pclk) begin
    if (apb.psel && apb.penable && !apb.pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (apb.psel && !apb.penable) setup_cnt <= setup_cnt + 1;
    if (rsp_valid && rsp_ready) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns #1 after the accepting edge with cmd_valid dropped.
  task automatic push_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [2:0] prot);
    int unsigned n = 0;
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
    cmd_wdata = wdata; cmd_strb = strb; cmd_prot = prot;
    while (!cmd_ready && n < 50) begin
      @(negedge pclk);
      n++;
    end
    if (!cmd_ready) check("push_accept", 32'd0, 32'd1);
    @(posedge pclk);
    #1 cmd_valid = 1'b0;
  endtask

  // Waits for rsp_valid, counting ACCESS cycles seen at falling edges.
  task automatic wait_rsp(input string tag, output int unsigned acc);
    int unsigned n = 0;
    acc = 0;
    @(negedge pclk);
    while (!rsp_valid && n < 40) begin
      if (apb.psel && apb.penable) acc++;
      @(negedge pclk);
      n++;
    end
    if (!rsp_valid) check({tag, "_rsp_timeout"}, 32'd0, 32'd1);
  endtask

  int unsigned acc, s0, r0;
  logic [31:0] held;

  initial begin
    // Reset state
    repeat (3) @(negedge pclk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_psel", apb.psel, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err_count", err_count, 0);
    presetn = 1'b1;
    #1 check("rel_cmd_ready_low", cmd_ready, 0);
    @(negedge pclk);
    check("rel_cmd_ready_high", cmd_ready, 1);

    // 1: write, zero wait states, edge-by-edge timing
    push_cmd(1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, PPROT_NONSEC);
    @(negedge pclk);
    check("w_e0_psel", apb.psel, 0);
    @(negedge pclk);
    check("w_e1_psel", apb.psel, 1);
    check("w_e1_penable", apb.penable, 0);
    check("w_paddr", apb.paddr, 32'h1000);
    check("w_pwrite", apb.pwrite, 1);
    check("w_pwdata", apb.pwdata, 32'hDEADBEEF);
    check("w_pstrb", apb.pstrb, 4'hF);
    check("w_pprot", apb.pprot, 3'b010);
    @(negedge pclk);
    check("w_e2_penable", apb.penable, 1);
    check("w_e2_rsp_valid", rsp_valid, 0);
    @(negedge pclk);
    check("w_e3_rsp_valid", rsp_valid, 1);
    check("w_e3_psel", apb.psel, 0);
    check("w_rsp_err", rsp_err, 0);
    check("w_rsp_rdata", rsp_rdata, 0);
    @(negedge pclk);
    check("w_drained", rsp_valid, 0);

    // 2: read with 2 wait states
    ws_cfg = 2; rdata_cfg = 32'h12345678;
    push_cmd(1'b0, 32'h2004, 32'hFFFFFFFF, 4'hF, 3'b000);
    @(negedge pclk); @(negedge pclk);
    check("r_pwrite", apb.pwrite, 0);
    check("r_pstrb", apb.pstrb, 0);
    check("r_pwdata", apb.pwdata, 0);
    check("r_paddr", apb.paddr, 32'h2004);
    wait_rsp("r", acc);
    check("r_access_cycles", acc, 3);
    check("r_rdata", rsp_rdata, 32'h12345678);
    check("r_err", rsp_err, 0);

    // 3: five back-to-back pushes with the response held
    ws_cfg = 0; rdata_cfg = 32'hA5A50001;
    @(negedge pclk); rsp_ready = 1'b0;
    s0 = setup_cnt; r0 = rsp_cnt;
    for (int i = 0; i < 5; i++) push_cmd(1'b0, 32'h3000 + 32'(4 * i), '0, 4'h0, 3'b000);
    @(negedge pclk);
    check("q_cmd_ready_full", cmd_ready, 0);
    held = rsp_rdata;
    repeat (10) @(negedge pclk);
    check("q_single_setup", setup_cnt - s0, 1);
    check("q_rsp_held", rsp_valid, 1);
    check("q_rdata_stable", rsp_rdata, held);
    check("q_busy", busy, 1);
    rsp_ready = 1'b1;
    for (int n = 0; n < 60 && busy; n++) @(negedge pclk);
    check("q_drain_idle", busy, 0);
    check("q_all_setups", setup_cnt - s0, 5);
    check("q_all_rsps", rsp_cnt - r0, 5);
    check("q_cmd_ready_back", cmd_ready, 1);

    // 4: timeout after 8 ACCESS cycles, then completion on the 8th
    stall_all = 1'b1; rdata_cfg = 32'hCAFEF00D;
    push_cmd(1'b0, 32'h4000, '0, 4'h0, 3'b000);
    wait_rsp("to", acc);
    check("to_access_cycles", acc, 8);
    check("to_err", rsp_err, 1);
    check("to_timeout", rsp_timeout, 1);
    check("to_rdata", rsp_rdata, 0);
    check("to_err_count", err_count, 1);
    stall_all = 1'b0; ws_cfg = 7;
    push_cmd(1'b0, 32'h4004, '0, 4'h0, 3'b000);
    wait_rsp("t8", acc);
    check("t8_access_cycles", acc, 8);
    check("t8_err", rsp_err, 0);
    check("t8_timeout", rsp_timeout, 0);
    check("t8_rdata", rsp_rdata, 32'hCAFEF00D);
    check("t8_err_count", err_count, 1);

    // 5: slave error on a write, then counter saturation
    ws_cfg = 0; slverr_cfg = 1'b1;
    push_cmd(1'b1, 32'h5000, 32'h1, 4'h3, 3'b001);
    wait_rsp("se", acc);
    check("se_err", rsp_err, 1);
    check("se_timeout", rsp_timeout, 0);
    check("se_err_count", err_count, 2);
    @(negedge pclk);
    force dut.err_cnt = 16'hFFFE;
    #1 release dut.err_cnt;
    push_cmd(1'b1, 32'h5004, 32'h2, 4'hF, 3'b000);
    wait_rsp("sat1", acc);
    check("sat_reach", err_count, 16'hFFFF);
    push_cmd(1'b1, 32'h5008, 32'h3, 4'hF, 3'b000);
    wait_rsp("sat2", acc);
    check("sat_hold", err_count, 16'hFFFF);
    slverr_cfg = 1'b0;

    // 6a: reset with a pending response and a queued command
    @(negedge pclk); rsp_ready = 1'b0;
    push_cmd(1'b1, 32'h6000, 32'h6, 4'hF, 3'b000);
    push_cmd(1'b1, 32'h6004, 32'h7, 4'hF, 3'b000);
    wait_rsp("ra", acc);
    #2 presetn = 1'b0;
    #1 check("ra_rsp_valid_async", rsp_valid, 0);
    check("ra_busy", busy, 0);
    check("ra_err_count", err_count, 0);
    @(negedge pclk); presetn = 1'b1; rsp_ready = 1'b1;
    @(negedge pclk);

    // 6b: reset in the middle of ACCESS
    stall_all = 1'b1;
    push_cmd(1'b1, 32'h7000, 32'h8, 4'hF, 3'b000);
    for (int n = 0; n < 10 && !apb.penable; n++) @(negedge pclk);
    check("rb_in_access", apb.penable, 1);
    #2 presetn = 1'b0;
    #1 check("rb_psel_async", apb.psel, 0);
    check("rb_penable_async", apb.penable, 0);
    @(negedge pclk); presetn = 1'b1; stall_all = 1'b0;
    s0 = setup_cnt;
    repeat (5) @(negedge pclk);
    check("rb_busy", busy, 0);
    check("rb_no_rsp", rsp_valid, 0);
    check("rb_no_setup", setup_cnt - s0, 0);
    check("rb_err_count", err_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
